// File: rtl/melody_player.sv
// Piezo melody player: seven fixed jingles selected by snd_mode, started/pre-empted by trig.
// Define MELODY_PLAYER_GAP_EN to insert a 20 ms silent gap between consecutive notes.
`timescale 1ns / 1ps

module melody_player #(
  parameter int unsigned TickCycles = 1000  // clk_1mhz cycles per 1 ms tick
) (
  input  logic       clk_1mhz,
  input  logic       rst,
  input  logic [2:0] snd_mode,
  input  logic       trig,
  output logic       playing,
  output logic       piezo_out
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
`ifdef MELODY_PLAYER_GAP_EN
    StGap  = 2'd2,
`endif
    StTone = 2'd1
  } state_e;

  localparam logic [9:0] PreMax = 10'(TickCycles - 1);
`ifdef MELODY_PLAYER_GAP_EN
  localparam logic [8:0] GapMs = 9'd20;
`endif

  state_e      state_q;
  logic [2:0]  mode_q;
  logic [2:0]  note_q;
  logic [9:0]  pre_q;
  logic [8:0]  ms_q;
  logic [11:0] hp_q;

  logic [11:0] half;
  logic [8:0]  dur;
  logic [2:0]  last_idx;
  logic        tick;
  logic        note_done;

  // Per-melody note table: half-period, note duration and index of the final note
  always_comb begin
    half     = 12'd1;
    dur      = 9'd1;
    last_idx = 3'd0;
    case (mode_q)
      3'd1: begin half = 12'd568;  dur = 9'd100; end
      3'd2: begin half = 12'd284;  dur = 9'd300; end
      3'd3: begin
        half     = (note_q == 3'd0) ? 12'd379 : 12'd284;
        dur      = 9'd50;
        last_idx = 3'd1;
      end
      3'd4: begin half = 12'd2273; dur = 9'd200; end
      3'd5: begin
        case (note_q)
          3'd0:    half = 12'd956;
          3'd1:    half = 12'd759;
          3'd2:    half = 12'd638;
          default: half = 12'd478;
        endcase
        dur      = 9'd150;
        last_idx = 3'd3;
      end
      3'd6: begin
        case (note_q)
          3'd0:    half = 12'd1276;
          3'd1:    half = 12'd1517;
          default: half = 12'd1908;
        endcase
        dur      = 9'd250;
        last_idx = 3'd2;
      end
      3'd7: begin
        case (note_q)
          3'd0:    half = 12'd956;
          3'd1:    half = 12'd759;
          3'd2:    half = 12'd638;
          3'd4:    half = 12'd638;
          default: half = 12'd478;
        endcase
        dur      = 9'd120;
        last_idx = 3'd5;
      end
      default: ;
    endcase
  end

  assign tick      = (pre_q == PreMax);
  assign note_done = tick && (ms_q == dur - 9'd1);

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mode_q    <= 3'd0;
      note_q    <= 3'd0;
      pre_q     <= 10'd0;
      ms_q      <= 9'd0;
      hp_q      <= 12'd0;
      piezo_out <= 1'b0;
    end else if (trig) begin
      // Start, pre-empt or abort all restart from a clean note 0
      note_q    <= 3'd0;
      pre_q     <= 10'd0;
      ms_q      <= 9'd0;
      hp_q      <= 12'd0;
      piezo_out <= 1'b0;
      mode_q    <= snd_mode;
      state_q   <= (snd_mode == 3'd0) ? StIdle : StTone;
    end else begin
      case (state_q)
        StTone: begin
          pre_q <= tick ? 10'd0 : pre_q + 10'd1;
          if (tick) ms_q <= ms_q + 9'd1;
          if (hp_q == half - 12'd1) begin
            hp_q      <= 12'd0;
            piezo_out <= ~piezo_out;
          end else begin
            hp_q <= hp_q + 12'd1;
          end
          if (note_done) begin
            ms_q      <= 9'd0;
            hp_q      <= 12'd0;
            piezo_out <= 1'b0;
            if (note_q == last_idx) begin
              state_q <= StIdle;
              note_q  <= 3'd0;
            end else begin
`ifdef MELODY_PLAYER_GAP_EN
              state_q <= StGap;
`else
              note_q  <= note_q + 3'd1;
`endif
            end
          end
        end
`ifdef MELODY_PLAYER_GAP_EN
        StGap: begin
          pre_q <= tick ? 10'd0 : pre_q + 10'd1;
          if (tick) begin
            if (ms_q == GapMs - 9'd1) begin
              ms_q    <= 9'd0;
              note_q  <= note_q + 3'd1;
              state_q <= StTone;
            end else begin
              ms_q <= ms_q + 9'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign playing = !rst && ((state_q != StIdle) || (trig && (snd_mode != 3'd0)));

endmodule
